// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_SHIFT     = 2;
  localparam int unsigned WORD_BITS      = BYTES_PER_WORD * 8;

endpackage

// File: rtl/program_loader_if.sv
// Load-request, byte-stream and program-memory write signals of the loader.
interface program_loader_if #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32
);
  localparam int unsigned CNT_BITS = $clog2(MEMORY_DEPTH) + 1;

  logic                  Start;
  logic [CNT_BITS-1:0]   WordCount;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemData;
  logic                  CpuHold;
  logic                  Done;
  logic                  Error;

  modport master (
    output Start, WordCount, ByteIn, ByteValid,
    input  ByteReady, MemWrite, MemAddress, MemData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, WordCount, ByteIn, ByteValid,
    output ByteReady, MemWrite, MemAddress, MemData, CpuHold, Done, Error
  );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter.
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 accept,
  input  logic                 clear,
  input  logic [7:0]           data,
  output logic                 word_complete,
  output logic [WORD_BITS-1:0] word
);
  logic [1:0]           cnt_q;
  logic [WORD_BITS-1:0] shift_q;

  // word already includes the byte being accepted, so it is valid with word_complete
  assign word          = {shift_q[WORD_BITS-9:0], data};
  assign word_complete = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= word;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Loads WordCount big-endian words from a byte stream into program memory, holding the CPU meanwhile.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);
  localparam int unsigned ADDR_BITS = $clog2(MEMORY_DEPTH);
  localparam int unsigned CNT_BITS  = ADDR_BITS + 1;

  state_t                state, state_next;
  logic [CNT_BITS-1:0]   count_q;
  logic [ADDR_BITS-1:0]  index_q;
  logic                  count_ok, start_ok, accept, last_word;
  logic                  word_complete;
  logic [WORD_BITS-1:0]  word;

  logic                  byte_ready_q, mem_write_q, cpu_hold_q, done_q, error_q;
  logic                  byte_ready_d, mem_write_d, cpu_hold_d, done_d, error_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_data_q, mem_addr_d, mem_data_d;

  assign count_ok  = (bus.WordCount != '0) && (bus.WordCount <= CNT_BITS'(MEMORY_DEPTH));
  assign start_ok  = (state == IDLE) && bus.Start && count_ok;
  assign accept    = bus.ByteValid && byte_ready_q;
  // compare index+1 at full count width so a 32-word load never wraps the index
  assign last_word = ({1'b0, index_q} + CNT_BITS'(1)) == count_q;

  byte_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .accept        (accept),
    .clear         (start_ok),
    .data          (bus.ByteIn),
    .word_complete (word_complete),
    .word          (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      byte_ready_q <= 1'b0;
      mem_write_q  <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state        <= state_next;
      byte_ready_q <= byte_ready_d;
      mem_write_q  <= mem_write_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = RECV;
      RECV:    if (word_complete) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : RECV;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    byte_ready_d = (state_next == RECV);
    cpu_hold_d   = (state_next == RECV) || (state_next == WRITE);
    mem_write_d  = (state == RECV) && word_complete;
    done_d       = (state == WRITE) && last_word;
    error_d      = (state == IDLE) && bus.Start && !count_ok;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    if (mem_write_d) begin
      mem_addr_d = DATA_WIDTH'(index_q) << ADDR_SHIFT;
      mem_data_d = DATA_WIDTH'(word);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      index_q <= '0;
    end else if (start_ok) begin
      count_q <= bus.WordCount;
      index_q <= '0;
    end else if ((state == WRITE) && !last_word) begin
      index_q <= index_q + ADDR_BITS'(1);
    end
  end

  assign bus.ByteReady  = byte_ready_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.MemAddress = mem_addr_q;
  assign bus.MemData    = mem_data_q;
  assign bus.CpuHold    = cpu_hold_q;
  assign bus.Done       = done_q;
  assign bus.Error      = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a byte/word-count reference model.
module tb_program_loader;
  localparam int DEPTH    = 32;
  localparam int CNT_BITS = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) bus ();
  program_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: a load is a count of words, bytes accumulate in a queue,
  // every 4th byte is written next cycle, and Done follows the write of the last word.
  int          cyc = 0;
  bit          m_loading = 1'b0;
  int          m_count = 0;
  int          m_nbytes = 0;
  int          m_loads_done = 0;
  int          m_last_acc_cyc = 0;
  logic [7:0]  m_q[$];
  logic [63:0] model_writes[$];
  logic        exp_ready = 0, exp_write = 0, exp_hold = 0, exp_done = 0, exp_error = 0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic        pr_ready, pr_write, pr_done, nw, nd, ne;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_loading = 1'b0; m_nbytes = 0; m_count = 0; m_q.delete();
      exp_ready = 0; exp_write = 0; exp_hold = 0; exp_done = 0; exp_error = 0;
      exp_addr = '0; exp_data = '0;
    end else begin
      pr_ready = exp_ready; pr_write = exp_write; pr_done = exp_done;
      nw = 0; nd = 0; ne = 0;
      if (!m_loading && !pr_done) begin
        if (bus.Start) begin
          if (bus.WordCount >= 1 && int'(bus.WordCount) <= DEPTH) begin
            m_loading = 1'b1; m_count = int'(bus.WordCount); m_nbytes = 0; m_q.delete();
          end else ne = 1;
        end
      end else if (m_loading) begin
        if (pr_write) begin
          if (m_nbytes / 4 == m_count) begin
            m_loading = 1'b0; nd = 1; m_loads_done++;
          end
        end else if (pr_ready && bus.ByteValid) begin
          m_q.push_back(bus.ByteIn);
          m_nbytes++;
          m_last_acc_cyc = cyc;
          if (m_nbytes % 4 == 0) begin
            nw = 1;
            exp_addr = 32'((m_nbytes / 4 - 1) * 4);
            exp_data = {m_q[m_nbytes-4], m_q[m_nbytes-3], m_q[m_nbytes-2], m_q[m_nbytes-1]};
            model_writes.push_back({exp_addr, exp_data});
          end
        end
      end
      exp_write = nw; exp_done = nd; exp_error = ne;
      exp_ready = m_loading && !nw;
      exp_hold  = m_loading;
      cyc++;
    end
  end

  logic [63:0] dut_writes[$];
  int          dut_done_cyc = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("ByteReady",  32'(bus.ByteReady), 32'(exp_ready));
      chk("MemWrite",   32'(bus.MemWrite),  32'(exp_write));
      chk("CpuHold",    32'(bus.CpuHold),   32'(exp_hold));
      chk("Done",       32'(bus.Done),      32'(exp_done));
      chk("Error",      32'(bus.Error),     32'(exp_error));
      chk("MemAddress", bus.MemAddress,     exp_addr);
      chk("MemData",    bus.MemData,        exp_data);
      if (bus.MemWrite) dut_writes.push_back({bus.MemAddress, bus.MemData});
      if (bus.Done) dut_done_cyc = cyc;
    end
  end

  logic [7:0] load_bytes[$];

  task automatic fill_random(input int wc);
    load_bytes.delete();
    for (int i = 0; i < wc * 4; i++) load_bytes.push_back(8'($urandom_range(255)));
  endtask

  task automatic run_load(input int wc, input int pct, input int stop_at, input int inject_at);
    int  base;
    bit  finished;
    base = m_loads_done;
    finished = 1'b0;
    dut_writes.delete();
    model_writes.delete();
    bus.Start = 1'b1;
    bus.WordCount = CNT_BITS'(wc);
    @(negedge clk);
    bus.Start = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (m_loads_done != base) begin finished = 1'b1; break; end
      if (stop_at >= 0 && m_nbytes >= stop_at) begin finished = 1'b1; break; end
      bus.Start = (k == inject_at);
      bus.WordCount = (k == inject_at) ? CNT_BITS'(1) : CNT_BITS'($urandom_range(63));
      bus.ByteValid = ($urandom_range(99) < pct);
      bus.ByteIn = (m_nbytes < load_bytes.size()) ? load_bytes[m_nbytes] : 8'($urandom_range(255));
      @(negedge clk);
    end
    bus.Start = 1'b0;
    bus.ByteValid = 1'b0;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL load_timeout actual=not_done expected=done wc=%0d", wc);
    end
    if (stop_at < 0) repeat (2) @(negedge clk);
  endtask

  task automatic bad_start(input int wc);
    bus.Start = 1'b1;
    bus.WordCount = CNT_BITS'(wc);
    @(negedge clk);
    bus.Start = 1'b0;
    chk("err_pulse", 32'(bus.Error), 32'd1);
    chk("err_no_ready", 32'(bus.ByteReady), 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(bus.Error), 32'd0);
    chk("err_idle_no_hold", 32'(bus.CpuHold), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.Start = 1'b0; bus.WordCount = '0; bus.ByteIn = '0; bus.ByteValid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ByteReady), 32'd0);
    chk("rst_write", 32'(bus.MemWrite), 32'd0);
    chk("rst_hold",  32'(bus.CpuHold), 32'd0);
    chk("rst_done",  32'(bus.Done), 32'd0);
    chk("rst_error", 32'(bus.Error), 32'd0);
    chk("rst_addr",  bus.MemAddress, 32'd0);
    chk("rst_data",  bus.MemData, 32'd0);
    checking = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    load_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
    run_load(2, 100, -1, -1);
    chk("dir_nwrites", 32'(dut_writes.size()), 32'd2);
    if (dut_writes.size() >= 2) begin
      chk("dir_addr0", dut_writes[0][63:32], 32'h0);
      chk("dir_data0", dut_writes[0][31:0],  32'h20080005);
      chk("dir_addr1", dut_writes[1][63:32], 32'h4);
      chk("dir_data1", dut_writes[1][31:0],  32'hAC090000);
    end
    if (model_writes.size() >= 2) begin
      chk("model_data0", model_writes[0][31:0], 32'h20080005);
      chk("model_data1", model_writes[1][31:0], 32'hAC090000);
    end

    bad_start(0);
    bad_start(33);

    for (int t = 0; t < 6; t++) begin
      int wc;
      wc = $urandom_range(1, 8);
      fill_random(wc);
      run_load(wc, (t == 0) ? 100 : $urandom_range(30, 90), -1, -1);
      chk("rnd_nwrites", 32'(dut_writes.size()), 32'(wc));
    end

    fill_random(3);
    run_load(3, 70, -1, 6);
    chk("inject_nwrites", 32'(dut_writes.size()), 32'd3);

    fill_random(2);
    run_load(2, 100, 2, -1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.ByteReady), 32'd0);
    chk("mid_rst_write", 32'(bus.MemWrite), 32'd0);
    chk("mid_rst_hold",  32'(bus.CpuHold), 32'd0);
    chk("mid_rst_done",  32'(bus.Done), 32'd0);
    chk("mid_rst_error", 32'(bus.Error), 32'd0);
    chk("mid_rst_addr",  bus.MemAddress, 32'd0);
    chk("mid_rst_data",  bus.MemData, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dut_writes.delete();
    repeat (4) @(negedge clk);
    chk("post_rst_nowrite", 32'(dut_writes.size()), 32'd0);
    fill_random(1);
    run_load(1, 60, -1, -1);
    chk("post_rst_nwrites", 32'(dut_writes.size()), 32'd1);
    if (dut_writes.size() >= 1) chk("post_rst_addr", dut_writes[0][63:32], 32'h0);

    fill_random(32);
    run_load(32, 60, -1, -1);
    chk("full_nwrites", 32'(dut_writes.size()), 32'd32);
    if (dut_writes.size() >= 1)
      chk("full_last_addr", dut_writes[dut_writes.size()-1][63:32], 32'h7C);
    chk("full_done_latency", 32'(dut_done_cyc - m_last_acc_cyc), 32'd2);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 32, giving the number of program-memory words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction word and address width.
REQ-003 The block SHALL define ADDR_BITS = clog2(MEMORY_DEPTH) and CNT_BITS = ADDR_BITS+1 as local constants.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port Start, input, 1: one-cycle request to begin a load.
REQ-007 Port WordCount, input, CNT_BITS: number of words to load, sampled only when Start is accepted.
REQ-008 Port ByteIn, input, 8: serial program byte.
REQ-009 Port ByteValid, input, 1: ByteIn is valid.
REQ-010 Port ByteReady, output, 1: loader accepts a byte this cycle.
REQ-011 Port MemWrite, output, 1: program-memory write strobe.
REQ-012 Port MemAddress, output, DATA_WIDTH: byte address of the write, always word-aligned (bits 1:0 = 0).
REQ-013 Port MemData, output, DATA_WIDTH: instruction word to write.
REQ-014 Port CpuHold, output, 1: holds the processor's PC/fetch while loading.
REQ-015 Port Done, output, 1: one-cycle pulse on load completion.
REQ-016 Port Error, output, 1: one-cycle pulse on a rejected Start.

Function
REQ-017 The FSM SHALL have the states IDLE, RECV, WRITE and DONE; all outputs SHALL be registered.
REQ-018 IDLE: on Start with 1 <= WordCount <= MEMORY_DEPTH, go to RECV, latch WordCount, clear the word index and byte count, and assert CpuHold from the next cycle.
REQ-019 IDLE: on Start with WordCount = 0 or WordCount > MEMORY_DEPTH, pulse Error for 1 cycle and stay in IDLE.
REQ-020 Start SHALL be ignored in any state other than IDLE.
REQ-021 ByteReady SHALL be 1 only in RECV; a byte transfers when ByteValid and ByteReady are both 1 on a clock edge.
REQ-022 Byte order SHALL be big-endian: the first accepted byte goes to MemData[31:24] and the fourth to [7:0].
REQ-023 ByteValid without ByteReady SHALL have no effect; no byte is lost or duplicated.
REQ-024 On the 4th accepted byte of a word, the FSM SHALL go to WRITE; MemWrite SHALL be 1 for exactly the next cycle.
REQ-025 During the write, MemAddress = word index x 4 and MemData = the assembled word; MemAddress and MemData SHALL hold their values while MemWrite is 0.
REQ-026 WRITE: increment the word index; if the new index equals the latched WordCount, go to DONE, otherwise go to RECV.
REQ-027 DONE: pulse Done for 1 cycle, deassert CpuHold in the same cycle, then return to IDLE.
REQ-028 Minimum latency from accepting byte 4 of the last word to the Done pulse SHALL be 2 cycles.
REQ-029 The word index SHALL never exceed MEMORY_DEPTH-1, so MemAddress stays at or below (MEMORY_DEPTH-1) x 4.

Reset
REQ-030 Reset SHALL force IDLE and clear the index, byte count, assembled word, MemAddress and MemData to 0.
REQ-031 Reset SHALL force MemWrite, ByteReady, CpuHold, Done and Error to 0.
REQ-032 Reset during a load SHALL discard any partial word; no MemWrite SHALL occur for it after reset is released.
REQ-033 After reset is released, the block SHALL wait for a new Start.

Structure
REQ-034 A shared package SHALL hold the state encoding enum plus the constants BYTES_PER_WORD = 4 and ADDR_SHIFT = 2.
REQ-035 One sub-module, byte_assembler, SHALL contain the shift register and the 2-bit byte counter; it takes an accept strobe and a clear input and outputs word_complete and word.

Verification
REQ-036 Reset, then Start with WordCount = 2 and bytes 20,08,00,05,AC,09,00,00 -> MemWrite at address 0x0 with data 0x20080005, MemWrite at 0x4 with 0xAC090000, then a Done pulse; CpuHold is 1 throughout the load.
REQ-037 Start with WordCount = 0, then with WordCount = 33 -> an Error pulse each time, state stays IDLE, and no ByteReady.
REQ-038 ByteValid toggled randomly with gaps, plus ByteValid held high during WRITE -> exactly 4 bytes consumed per word and the data is correct.
REQ-039 Reset asserted after 2 bytes of word 1 -> all outputs are 0 immediately; a new load of 1 word writes to address 0x0.
REQ-040 WordCount = 32 full load -> last write at 0x7C, no write beyond it, and Done follows 2 cycles after the last byte.
REQ-041 Start pulsed in RECV with WordCount = 1 -> it is ignored and the original count completes.
